// File: rtl/signed_calc_arb_v_if.sv
// Requester / calculator signal bundle for signed_calc_arb_v.
// slave: arbiter side; master: parent side driving requests and the calculator result.
interface signed_calc_arb_v_if;
    logic       i_req0;
    logic [4:0] i_as0;
    logic [4:0] i_bs0;
    logic       i_req1;
    logic [4:0] i_as1;
    logic [4:0] i_bs1;
    logic [4:0] o_calc_as;
    logic [4:0] o_calc_bs;
    logic [8:0] i_calc_fs;
    logic [8:0] o_res;
    logic       o_done0;
    logic       o_done1;
    logic       o_busy;
    logic [1:0] o_gnt;

    modport slave (
        input  i_req0, i_as0, i_bs0, i_req1, i_as1, i_bs1, i_calc_fs,
        output o_calc_as, o_calc_bs, o_res, o_done0, o_done1, o_busy, o_gnt
    );

    modport master (
        output i_req0, i_as0, i_bs0, i_req1, i_as1, i_bs1, i_calc_fs,
        input  o_calc_as, o_calc_bs, o_res, o_done0, o_done1, o_busy, o_gnt
    );
endinterface

// File: rtl/signed_calc_arb_v.sv
// Round-robin arbiter sharing one signed_calc_v between two requesters:
// latch winner's operands, wait SETTLE_CYCLES, capture result, pulse done.
module signed_calc_arb_v #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    signed_calc_arb_v_if.slave   bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;
    logic [4:0]       as_q, as_d;
    logic [4:0]       bs_q, bs_d;
    logic [8:0]       res_q, res_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             pick1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        as_d    = as_q;
        bs_d    = bs_q;
        res_d   = res_q;
        gnt_d   = gnt_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        // ptr_q=1 gives requester 1 priority only when both are waiting
        pick1   = bus.i_req1 && (!bus.i_req0 || ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.i_req0 || bus.i_req1) begin
                    gnt_d   = pick1 ? 2'b10 : 2'b01;
                    as_d    = pick1 ? bus.i_as1 : bus.i_as0;
                    bs_d    = pick1 ? bus.i_bs1 : bus.i_bs0;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    res_d   = bus.i_calc_fs;
                    done0_d = gnt_q[0];
                    done1_d = gnt_q[1];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                ptr_d   = gnt_q[0];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            as_q    <= '0;
            bs_q    <= '0;
            res_q   <= '0;
            gnt_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            as_q    <= as_d;
            bs_q    <= bs_d;
            res_q   <= res_d;
            gnt_q   <= gnt_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign bus.o_calc_as = as_q;
    assign bus.o_calc_bs = bs_q;
    assign bus.o_res     = res_q;
    assign bus.o_done0   = done0_q;
    assign bus.o_done1   = done1_q;
    assign bus.o_gnt     = gnt_q;
    assign bus.o_busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_signed_calc_arb_v.sv
// Directed bench for signed_calc_arb_v; a stand-in signed multiplier plays signed_calc_v.
module tb_signed_calc_arb_v;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    signed_calc_arb_v_if a ();
    signed_calc_arb_v_if b ();

    signed_calc_arb_v #(.SETTLE_CYCLES(2), .CNT_W(4)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(a));
    signed_calc_arb_v #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(b));

    function automatic logic [8:0] calc_model(input logic [4:0] x, input logic [4:0] y);
        logic signed [9:0] p;
        p = $signed({{5{x[4]}}, x}) * $signed({{5{y[4]}}, y});
        return p[8:0];
    endfunction

    assign a.i_calc_fs = calc_model(a.o_calc_as, a.o_calc_bs);
    assign b.i_calc_fs = calc_model(b.o_calc_as, b.o_calc_bs);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        a.i_req0 = 0; a.i_as0 = '0; a.i_bs0 = '0;
        a.i_req1 = 0; a.i_as1 = '0; a.i_bs1 = '0;
        b.i_req0 = 0; b.i_as0 = '0; b.i_bs0 = '0;
        b.i_req1 = 0; b.i_as1 = '0; b.i_bs1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (a.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", a.o_busy); end
        checks++; if (a.o_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", a.o_gnt); end
        checks++; if (a.o_res !== 9'h000) begin failures++; $display("FAIL reset_res got=%h exp=000", a.o_res); end
        checks++; if ({a.o_done0, a.o_done1} !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", {a.o_done0, a.o_done1}); end
        checks++; if ({a.o_calc_as, a.o_calc_bs} !== 10'h000) begin failures++; $display("FAIL reset_calc got=%h exp=000", {a.o_calc_as, a.o_calc_bs}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        a.i_req0 = 1; a.i_as0 = 5'b00011; a.i_bs0 = 5'b00010;
        tick();  // edge k: grant
        checks++; if (a.o_gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", a.o_gnt); end
        checks++; if ({a.o_calc_as, a.o_calc_bs} !== {5'b00011, 5'b00010}) begin failures++; $display("FAIL single_ops got=%b_%b exp=00011_00010", a.o_calc_as, a.o_calc_bs); end
        checks++; if (a.o_busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", a.o_busy); end
        tick();  // k+1
        checks++; if (a.o_done0 !== 1'b0) begin failures++; $display("FAIL single_early_done got=%b exp=0", a.o_done0); end
        tick();  // k+2: capture
        a.i_req0 = 0;
        checks++; if (a.o_done0 !== 1'b1) begin failures++; $display("FAIL single_done0 got=%b exp=1", a.o_done0); end
        checks++; if (a.o_done1 !== 1'b0) begin failures++; $display("FAIL single_done1 got=%b exp=0", a.o_done1); end
        checks++; if (a.o_res !== 9'h006) begin failures++; $display("FAIL single_res got=%h exp=006", a.o_res); end
        tick();  // k+3: back to idle
        checks++; if ({a.o_done0, a.o_busy, a.o_gnt} !== 4'b0000) begin failures++; $display("FAIL single_idle got=%b exp=0000", {a.o_done0, a.o_busy, a.o_gnt}); end
        checks++; if (a.o_res !== 9'h006) begin failures++; $display("FAIL single_res_hold got=%h exp=006", a.o_res); end
    endtask

    task automatic test_alternation();
        logic [1:0] exp_gnt [3] = '{2'b01, 2'b10, 2'b01};
        logic [8:0] exp_res [3] = '{9'h006, 9'h1F6, 9'h006};
        do_reset();
        a.i_req0 = 1; a.i_as0 = 5'b00011; a.i_bs0 = 5'b00010;
        a.i_req1 = 1; a.i_as1 = 5'b11110; a.i_bs1 = 5'b00101;  // -2 * 5 = -10
        for (int op = 0; op < 3; op++) begin
            tick();
            checks++; if (a.o_gnt !== exp_gnt[op]) begin failures++; $display("FAIL alt_gnt op=%0d got=%b exp=%b", op, a.o_gnt, exp_gnt[op]); end
            for (int c = 1; c < 4; c++) begin
                tick();
                checks++;
                if ({a.o_done1, a.o_done0} !== ((c == 2) ? exp_gnt[op] : 2'b00)) begin
                    failures++;
                    $display("FAIL alt_done op=%0d cyc=%0d got=%b exp=%b", op, c, {a.o_done1, a.o_done0}, (c == 2) ? exp_gnt[op] : 2'b00);
                end
                if (c == 2) begin
                    checks++; if (a.o_res !== exp_res[op]) begin failures++; $display("FAIL alt_res op=%0d got=%h exp=%h", op, a.o_res, exp_res[op]); end
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_operand_change();
        do_reset();
        a.i_req1 = 1; a.i_as1 = 5'b11111; a.i_bs1 = 5'b01111;
        tick();
        checks++; if (a.o_gnt !== 2'b10) begin failures++; $display("FAIL opchg_gnt got=%b exp=10", a.o_gnt); end
        a.i_as1 = 5'b00000;
        tick();
        checks++; if (a.o_calc_as !== 5'b11111) begin failures++; $display("FAIL opchg_hold got=%b exp=11111", a.o_calc_as); end
        a.i_req1 = 0;
        tick();
        checks++; if (a.o_done1 !== 1'b1) begin failures++; $display("FAIL opchg_done1 got=%b exp=1", a.o_done1); end
        checks++; if (a.o_res !== 9'h1F1) begin failures++; $display("FAIL opchg_res got=%h exp=1f1", a.o_res); end
        tick();
    endtask

    task automatic test_drop();
        int n_done;
        do_reset();
        a.i_req0 = 1; a.i_as0 = 5'b00101; a.i_bs0 = 5'b00011;
        tick();
        a.i_req0 = 0;
        checks++; if (a.o_gnt !== 2'b01) begin failures++; $display("FAIL drop_gnt got=%b exp=01", a.o_gnt); end
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (a.o_done0) n_done++;
            if (c == 1) begin
                checks++; if (a.o_res !== 9'h00F) begin failures++; $display("FAIL drop_res got=%h exp=00f", a.o_res); end
            end
        end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL drop_done_count got=%0d exp=1", n_done); end
        checks++; if ({a.o_busy, a.o_gnt} !== 3'b000) begin failures++; $display("FAIL drop_idle got=%b exp=000", {a.o_busy, a.o_gnt}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        a.i_req0 = 1; a.i_as0 = 5'b00011; a.i_bs0 = 5'b00010;
        repeat (4) tick();
        a.i_req0 = 0;
        checks++; if (a.o_res !== 9'h006) begin failures++; $display("FAIL rmid_pre_res got=%h exp=006", a.o_res); end
        a.i_req1 = 1; a.i_as1 = 5'b00001; a.i_bs1 = 5'b00001;
        tick();
        checks++; if (a.o_gnt !== 2'b10) begin failures++; $display("FAIL rmid_gnt got=%b exp=10", a.o_gnt); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if ({a.o_busy, a.o_gnt, a.o_done1} !== 4'b0000) begin failures++; $display("FAIL rmid_abort got=%b exp=0000", {a.o_busy, a.o_gnt, a.o_done1}); end
        checks++; if (a.o_res !== 9'h000) begin failures++; $display("FAIL rmid_res got=%h exp=000", a.o_res); end
        a.i_req0 = 1;
        tick();
        checks++; if (a.o_gnt !== 2'b01) begin failures++; $display("FAIL rmid_ptr got=%b exp=01", a.o_gnt); end
        clear_inputs();
        repeat (4) tick();
    endtask

    task automatic test_settle1();
        logic exp_done;
        do_reset();
        b.i_req0 = 1; b.i_as0 = 5'b00011; b.i_bs0 = 5'b00010;
        for (int c = 0; c < 9; c++) begin
            tick();
            exp_done = (c % 3 == 1);
            checks++; if (b.o_done0 !== exp_done) begin failures++; $display("FAIL s1_done cyc=%0d got=%b exp=%b", c, b.o_done0, exp_done); end
            if (c == 1) begin
                checks++; if (b.o_res !== 9'h006) begin failures++; $display("FAIL s1_res got=%h exp=006", b.o_res); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_alternation();
        test_operand_change();
        test_drop();
        test_reset_mid();
        test_settle1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/signed_calc_arb_v.md
Name: signed_calc_arb_v

Overview:
- Controller that shares one signed_calc_v instance between two requesters.
- Arbitrates round-robin and latches the winner's 5-bit operands into the calculator inputs.
- Waits a fixed settle time, captures the 9-bit result, and returns it with a one-cycle done pulse to the granted requester.
- Sits between the operand sources and signed_calc_v; the calculator itself is instantiated by the parent and wired to the o_calc_* / i_calc_fs ports.

Parameters:
- SETTLE_CYCLES, 2, clock cycles the operands are held on the calculator before the result is captured (legal range 1..15).
- CNT_W, 4, width of the settle counter (must hold SETTLE_CYCLES-1).

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_req0  input  1  requester 0 operation request (level)
- i_as0  input  5  requester 0 operand A
- i_bs0  input  5  requester 0 operand B
- i_req1  input  1  requester 1 operation request (level)
- i_as1  input  5  requester 1 operand A
- i_bs1  input  5  requester 1 operand B
- o_calc_as  output  5  operand A driven to signed_calc_v
- o_calc_bs  output  5  operand B driven to signed_calc_v
- i_calc_fs  input  9  result from signed_calc_v
- o_res  output  9  captured result, shared by both requesters
- o_done0  output  1  one-cycle pulse: o_res valid for requester 0
- o_done1  output  1  one-cycle pulse: o_res valid for requester 1
- o_busy  output  1  high in SETTLE and DONE states
- o_gnt  output  2  one-hot owner of the current operation, 00 when idle

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n, sampled on the rising edge of i_clk.
- Reset values:
  - State IDLE, counter 0, round-robin pointer favours requester 0.
  - o_calc_as = 0, o_calc_bs = 0, o_res = 0.
  - o_done0 = o_done1 = 0, o_busy = 0, o_gnt = 00.
- IDLE:
  - Only one request high: grant it.
  - Both high: grant the pointer's requester.
  - On the grant edge, latch that requester's as/bs into o_calc_as/o_calc_bs, set o_gnt one-hot, clear counter, go to SETTLE.
  - No request: stay in IDLE; o_calc_* keep their last values.
- SETTLE:
  - Counter increments each edge.
  - On the edge where counter == SETTLE_CYCLES-1: o_res <= i_calc_fs, assert the granted o_doneN, go to DONE.
- DONE (one cycle):
  - Next edge clears o_doneN and o_gnt, moves the pointer to the other requester, and returns to IDLE.
- Latency and throughput:
  - Request sampled at edge k -> o_doneN high after edge k+SETTLE_CYCLES, for exactly one cycle.
  - Back-to-back throughput is one operation per SETTLE_CYCLES+2 cycles.
- Operand latching: operands are latched at grant. Requester inputs may change or requests may drop during SETTLE without affecting the operation; done is still pulsed.
- Repeated requests: a request still high in IDLE after its done counts as a new request. The pointer then gives the other requester priority if it is also waiting.
- Arithmetic: none. o_res is a bit-exact copy of i_calc_fs sampled at the capture edge and held until the next capture.
- Exclusivity: o_done0 and o_done1 are never high together and never high outside DONE.
- Reset mid-operation (SETTLE or DONE): abort with no done pulse, o_res cleared, pointer returned to requester 0.

Test Plan:
- Single request: reset, then i_req0=1, i_as0=00011, i_bs0=00010 at edge k -> o_gnt=01 at k, o_calc_as=00011, o_calc_bs=00010, o_done0 pulse after edge k+2 (SETTLE_CYCLES=2), o_res equals signed_calc_v output for those operands; o_done1 stays 0.
- Simultaneous requests: after reset, i_req0=i_req1=1 held -> requester 0 served first, then requester 1, then 0 (strict alternation). Done pulses are 4 cycles apart with no overlap.
- Operand change during SETTLE: grant requester 1 with as=11111, bs=01111, then change i_as1 to 00000 one cycle later -> o_calc_as stays 11111 and o_res reflects 11111 x 01111.
- Request dropped mid-operation: i_req0 pulsed high for one cycle only -> full operation completes, o_done0 pulses once, FSM returns to IDLE with o_gnt=00.
- Reset mid-SETTLE: i_rst_n=0 one cycle after grant -> next edge o_busy=0, o_gnt=00, o_res=0, no done pulse. With both requests high after release, requester 0 is granted first.
- SETTLE_CYCLES=1 build: single request -> done after edge k+1; back-to-back single requester sees one done every 3 cycles.
